// File: rtl/fetch_pkg.sv
// Shared fetch-stage defaults and opcode field constants, used by fetch, decode and the bench.
package fetch_pkg;

    localparam int FETCH_ADDR_W   = 4;
    localparam int FETCH_INSTR_W  = 16;
    localparam int FETCH_RESET_PC = 0;

    localparam int         OP_MSB  = 15;
    localparam int         OP_LSB  = 12;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_OUT  = 4'b1111;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset, redirect and increment-on-load.
// With FETCH_HALT_ON_WRAP_EN defined, a load at the last ROM address parks the pc there and raises halted.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = FETCH_ADDR_W,
    parameter int RESET_PC = FETCH_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              load,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    logic inc_en;

`ifdef FETCH_HALT_ON_WRAP_EN
    localparam logic [ADDR_W-1:0] PC_LAST = '1;
    logic halted_q;

    // The final load still delivers its instruction; only the pc stops moving.
    assign inc_en = load & (pc != PC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (jump_en) begin
            halted_q <= 1'b0;
        end else if (load && pc == PC_LAST) begin
            halted_q <= 1'b1;
        end
    end

    assign halted = halted_q;
`else
    assign inc_en = load;
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (jump_en) begin
            pc <= jump_target;
        end else if (inc_en) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives the ROM address from the pc, captures the ROM word and hands it to decode via valid/ready.
// Optional halt-at-end-of-program behaviour is selected by FETCH_HALT_ON_WRAP_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = FETCH_ADDR_W,
    parameter int INSTR_W  = FETCH_INSTR_W,
    parameter int RESET_PC = FETCH_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_instr,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               halted
);

    logic [ADDR_W-1:0] pc;
    logic              load;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .load        (load),
        .pc          (pc),
        .halted      (halted)
    );

    assign rom_addr = pc;
    assign load     = run & ~jump_en & ~halted & (~instr_valid | instr_ready);

    // A redirect flushes the IR even if decode is ready: that handshake never completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (jump_en) begin
            instr_valid <= 1'b0;
        end else if (load) begin
            instr       <= rom_instr;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
        end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 16-entry ROM model; follows FETCH_HALT_ON_WRAP_EN if defined.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  rom_addr;
    logic [15:0] rom_instr;
    logic        jump_en;
    logic [3:0]  jump_target;
    logic [15:0] instr;
    logic [3:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;

    logic [15:0] rom [16];
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    assign rom_instr = rom[rom_addr];

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .rom_addr    (rom_addr),
        .rom_instr   (rom_instr),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_target = 4'd0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if ({instr_valid, instr_pc, instr, rom_addr, halted} !== {1'b0, 4'd0, 16'h0000, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset got v=%b pc=%0d i=%h a=%0d h=%b exp v=0 pc=0 i=0000 a=0 h=0",
                     instr_valid, instr_pc, instr, rom_addr, halted);
        end
        checks++;
    endtask

    task automatic test_stream();
        logic [15:0] exp_i [3];
        exp_i[0] = 16'h1000; exp_i[1] = 16'hF000; exp_i[2] = 16'h1201;
        do_reset();
        run = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if ({instr_valid, instr_pc, instr} !== {1'b1, 4'(k), exp_i[k]}) begin
                fails++;
                $display("FAIL stream_c%0d got v=%b pc=%0d i=%h exp v=1 pc=%0d i=%h",
                         k + 1, instr_valid, instr_pc, instr, k, exp_i[k]);
            end
            checks++;
        end
        for (int k = 3; k < 8; k++) begin
            step();
            if ({instr_valid, instr_pc, instr} !== {1'b1, 4'(k), rom[k]}) begin
                fails++;
                $display("FAIL stream_pc%0d got v=%b pc=%0d i=%h exp v=1 pc=%0d i=%h",
                         k, instr_valid, instr_pc, instr, k, rom[k]);
            end
            checks++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        run = 1'b1; instr_ready = 1'b0;
        step();
        if (instr[OP_MSB:OP_LSB] !== OP_ADDI) begin
            fails++;
            $display("FAIL bp_opcode got %h exp %h", instr[OP_MSB:OP_LSB], OP_ADDI);
        end
        checks++;
        for (int k = 0; k < 3; k++) begin
            step();
            if ({instr_valid, instr_pc, instr, rom_addr} !== {1'b1, 4'd0, 16'h1000, 4'd1}) begin
                fails++;
                $display("FAIL bp_hold%0d got v=%b pc=%0d i=%h a=%0d exp v=1 pc=0 i=1000 a=1",
                         k, instr_valid, instr_pc, instr, rom_addr);
            end
            checks++;
        end
        instr_ready = 1'b1;
        step();
        if ({instr_valid, instr_pc, instr, rom_addr} !== {1'b1, 4'd1, 16'hF000, 4'd2}) begin
            fails++;
            $display("FAIL bp_release got v=%b pc=%0d i=%h a=%0d exp v=1 pc=1 i=f000 a=2",
                     instr_valid, instr_pc, instr, rom_addr);
        end
        checks++;
        if (instr[OP_MSB:OP_LSB] !== OP_OUT) begin
            fails++;
            $display("FAIL bp_opcode_out got %h exp %h", instr[OP_MSB:OP_LSB], OP_OUT);
        end
        checks++;
    endtask

    // Continues from test_backpressure: valid, ready high.
    task automatic test_jump();
        jump_en = 1'b1; jump_target = 4'd14;
        step();
        if ({instr_valid, rom_addr} !== {1'b0, 4'd14}) begin
            fails++;
            $display("FAIL jump_flush got v=%b a=%0d exp v=0 a=14", instr_valid, rom_addr);
        end
        checks++;
        jump_en = 1'b0;
        step();
        if ({instr_valid, instr_pc, instr} !== {1'b1, 4'd14, 16'h1E07}) begin
            fails++;
            $display("FAIL jump_target got v=%b pc=%0d i=%h exp v=1 pc=14 i=1e07",
                     instr_valid, instr_pc, instr);
        end
        checks++;
    endtask

    // Continues from test_jump: pc=15 presented to the ROM.
    task automatic test_wrap();
        step();
`ifdef FETCH_HALT_ON_WRAP_EN
        if ({instr_valid, instr_pc, instr, rom_addr, halted} !== {1'b1, 4'd15, 16'hFE07, 4'd15, 1'b1}) begin
            fails++;
            $display("FAIL wrap_last got v=%b pc=%0d i=%h a=%0d h=%b exp v=1 pc=15 i=fe07 a=15 h=1",
                     instr_valid, instr_pc, instr, rom_addr, halted);
        end
        checks++;
        step();
        if ({instr_valid, rom_addr, halted} !== {1'b0, 4'd15, 1'b1}) begin
            fails++;
            $display("FAIL wrap_halt got v=%b a=%0d h=%b exp v=0 a=15 h=1", instr_valid, rom_addr, halted);
        end
        checks++;
        step();
        if ({instr_valid, rom_addr, halted} !== {1'b0, 4'd15, 1'b1}) begin
            fails++;
            $display("FAIL wrap_stay got v=%b a=%0d h=%b exp v=0 a=15 h=1", instr_valid, rom_addr, halted);
        end
        checks++;
`else
        if ({instr_valid, instr_pc, instr, rom_addr, halted} !== {1'b1, 4'd15, 16'hFE07, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL wrap_last got v=%b pc=%0d i=%h a=%0d h=%b exp v=1 pc=15 i=fe07 a=0 h=0",
                     instr_valid, instr_pc, instr, rom_addr, halted);
        end
        checks++;
        step();
        if ({instr_valid, instr_pc, instr, halted} !== {1'b1, 4'd0, 16'h1000, 1'b0}) begin
            fails++;
            $display("FAIL wrap_zero got v=%b pc=%0d i=%h h=%b exp v=1 pc=0 i=1000 h=0",
                     instr_valid, instr_pc, instr, halted);
        end
        checks++;
`endif
        jump_en = 1'b1; jump_target = 4'd0;
        step();
        if ({instr_valid, rom_addr, halted} !== {1'b0, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL wrap_jump got v=%b a=%0d h=%b exp v=0 a=0 h=0", instr_valid, rom_addr, halted);
        end
        checks++;
        jump_en = 1'b0;
        step();
        if ({instr_valid, instr_pc, instr} !== {1'b1, 4'd0, 16'h1000}) begin
            fails++;
            $display("FAIL wrap_refetch got v=%b pc=%0d i=%h exp v=1 pc=0 i=1000",
                     instr_valid, instr_pc, instr);
        end
        checks++;
    endtask

    task automatic test_rst_mid();
        do_reset();
        run = 1'b1; instr_ready = 1'b1;
        step(); step(); step();
        instr_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        if ({instr_valid, instr_pc, instr, rom_addr} !== {1'b0, 4'd0, 16'h0000, 4'd0}) begin
            fails++;
            $display("FAIL rst_mid got v=%b pc=%0d i=%h a=%0d exp v=0 pc=0 i=0000 a=0",
                     instr_valid, instr_pc, instr, rom_addr);
        end
        checks++;
        rst = 1'b0; instr_ready = 1'b1;
        step();
        if ({instr_valid, instr_pc, instr} !== {1'b1, 4'd0, 16'h1000}) begin
            fails++;
            $display("FAIL rst_refetch got v=%b pc=%0d i=%h exp v=1 pc=0 i=1000",
                     instr_valid, instr_pc, instr);
        end
        checks++;
    endtask

    task automatic test_run_freeze();
        do_reset();
        run = 1'b1; instr_ready = 1'b1;
        step(); step();
        run = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            if ({instr_valid, rom_addr} !== {1'b0, 4'd2}) begin
                fails++;
                $display("FAIL freeze%0d got v=%b a=%0d exp v=0 a=2", k, instr_valid, rom_addr);
            end
            checks++;
        end
        run = 1'b1;
        step();
        if ({instr_valid, instr_pc, instr} !== {1'b1, 4'd2, 16'h1201}) begin
            fails++;
            $display("FAIL resume got v=%b pc=%0d i=%h exp v=1 pc=2 i=1201", instr_valid, instr_pc, instr);
        end
        checks++;
    endtask

    initial begin
        rom[0]  = 16'h1000; rom[1]  = 16'hF000; rom[2]  = 16'h1201; rom[3]  = 16'h1103;
        rom[4]  = 16'h1104; rom[5]  = 16'hF005; rom[6]  = 16'h1206; rom[7]  = 16'h1307;
        rom[8]  = 16'h1008; rom[9]  = 16'hF009; rom[10] = 16'h120A; rom[11] = 16'h130B;
        rom[12] = 16'h100C; rom[13] = 16'hF00D; rom[14] = 16'h1E07; rom[15] = 16'hFE07;

        test_reset();
        test_stream();
        test_backpressure();
        test_jump();
        test_wrap();
        test_rst_mid();
        test_run_freeze();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
